// File: rtl/p2p_egress_rr_mux_pkg.sv
// Shared types, entry/header field offsets and the round-robin pick helper
// for the P2P egress mux.
package p2p_egress_rr_mux_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam int MAX_QUEUES = 8;

    // Entry metadata offsets, relative to the top of the body (C_DATA_WIDTH)
    localparam int ENT_META_W  = 32;
    localparam int ENT_START   = 0;
    localparam int ENT_END     = 1;
    localparam int ENT_KEEP_LO = 2;
    localparam int ENT_KEEP_W  = 5;
    localparam int ENT_LEN_LO  = 7;
    localparam int ENT_LEN_W   = 16;
    localparam int ENT_SRC_LO  = 23;
    localparam int ENT_DST_LO  = 26;
    localparam int ENT_RSVD_LO = 29;
    localparam int ENT_DEV_W   = 3;

    localparam int HEAD_LEN_LO = 0;
    localparam int HEAD_SRC_LO = 32;
    localparam int HEAD_DST_LO = 35;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    // Debug view of the arbiter and of the metadata not carried on p2p_tx
    typedef struct packed {
        arb_state_e state;
        logic [2:0] rr_ptr;
        logic [2:0] grant;
        logic       sop;
        logic [4:0] keep;
        logic [2:0] rsvd;
    } arb_dbg_t;

    // First requester strictly after base, wrapping modulo n; base itself is checked last.
    function automatic rr_pick_t rr_pick(input logic [MAX_QUEUES-1:0] req, input int base, input int n);
        rr_pick_t   r;
        logic [2:0] idx;
        r = '0;
        for (int i = 1; i <= MAX_QUEUES; i++) begin
            idx = 3'((base + i) % n);
            if (!r.found && i <= n && req[idx]) begin
                r.found = 1'b1;
                r.idx   = idx;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/p2p_egress_rr_mux_if.sv
// p2p_tx up-channel bundle between the egress mux (master) and its sink (slave).
interface p2p_egress_rr_mux_if #(
    parameter int C_DATA_WIDTH     = 256,
    parameter int UPPER_HEAD_WIDTH = 64
);
    // A beat transfers on a rising edge where p2p_tx_valid && p2p_tx_ready; while valid is
    // high and ready is low, valid/last/data/head hold their values.
    logic                        p2p_tx_valid;
    logic                        p2p_tx_last;
    logic [C_DATA_WIDTH-1:0]     p2p_tx_data;
    logic [UPPER_HEAD_WIDTH-1:0] p2p_tx_head;
    logic                        p2p_tx_ready;

    modport master (
        output p2p_tx_valid, p2p_tx_last, p2p_tx_data, p2p_tx_head,
        input  p2p_tx_ready
    );

    modport slave (
        input  p2p_tx_valid, p2p_tx_last, p2p_tx_data, p2p_tx_head,
        output p2p_tx_ready
    );
endinterface

// File: rtl/p2p_sync_fifo.sv
// First-word-fall-through queue with occupancy count, registered prog_full
// and a sticky overflow flag for writes dropped while full.
module p2p_sync_fifo #(
    parameter int WIDTH            = 288,
    parameter int DEPTH            = 32,
    parameter int PROG_FULL_THRESH = 24,
    parameter int CNT_W            = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             prog_full_o,
    input  logic             overflow_clr_i,
    output logic             overflow_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             prog_full_q, overflow_q;
    logic             full, wr_ok, rd_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign wr_ok   = wr_en_i && !full;
    assign rd_ok   = rd_en_i && !empty_o;

    always_comb begin
        count_d = count_q;
        if (wr_ok && !rd_ok)
            count_d = count_q + CNT_W'(1);
        else if (!wr_ok && rd_ok)
            count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            prog_full_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q     <= count_d;
            prog_full_q <= (count_d >= CNT_W'(PROG_FULL_THRESH));
            // A new overflow in the same cycle as a clear wins
            if (wr_en_i && full)
                overflow_q <= 1'b1;
            else if (overflow_clr_i)
                overflow_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o   = mem_q[rd_ptr_q];
    assign count_o     = count_q;
    assign prog_full_o = prog_full_q;
    assign overflow_o  = overflow_q;
endmodule

// File: rtl/p2p_egress_rr_mux.sv
// N-queue P2P egress mux: per-queue FWFT FIFOs drained packet-atomically onto
// p2p_tx with per-packet round-robin and zero-bubble back-to-back packets.
module p2p_egress_rr_mux
    import p2p_egress_rr_mux_pkg::*;
#(
    parameter int NUM_QUEUES       = 4,
    parameter int QUEUE_DEPTH      = 32,
    parameter int PROG_FULL_THRESH = 24,
    parameter int C_DATA_WIDTH     = 256,
    parameter int UPPER_HEAD_WIDTH = 64
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [NUM_QUEUES-1:0]                         iv_queue_wr_en,
    input  logic [NUM_QUEUES*(C_DATA_WIDTH+ENT_META_W)-1:0] iv_queue_data,
    output logic [NUM_QUEUES-1:0]                         ov_queue_prog_full,
    output logic [NUM_QUEUES-1:0]                         ov_queue_overflow,
    input  logic                                          i_overflow_clr,
    p2p_egress_rr_mux_if.master                           tx,
    output arb_dbg_t                                      dbg_o
);
    localparam int ENTRY_W = C_DATA_WIDTH + ENT_META_W;
    localparam int CNT_W   = $clog2(QUEUE_DEPTH) + 1;
    localparam int GW      = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;

    logic [ENTRY_W-1:0]          q_dout [NUM_QUEUES];
    logic [CNT_W-1:0]            q_cnt  [NUM_QUEUES];
    logic [NUM_QUEUES-1:0]       q_empty, rd_en;

    arb_state_e                  state_q, state_d;
    logic [GW-1:0]               grant_q, grant_d, rr_ptr_q, rr_ptr_d;
    logic [ENTRY_W-1:0]          cur;
    logic                        beat_valid, beat_last;
    logic [UPPER_HEAD_WIDTH-1:0] head;
    logic [MAX_QUEUES-1:0]       req;
    int                          base;
    rr_pick_t                    pick;

    for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_queue
        p2p_sync_fifo #(
            .WIDTH(ENTRY_W), .DEPTH(QUEUE_DEPTH), .PROG_FULL_THRESH(PROG_FULL_THRESH), .CNT_W(CNT_W)
        ) u_fifo (
            .clk            (clk),
            .rst            (rst),
            .wr_en_i        (iv_queue_wr_en[q]),
            .wr_data_i      (iv_queue_data[q*ENTRY_W +: ENTRY_W]),
            .rd_en_i        (rd_en[q]),
            .rd_data_o      (q_dout[q]),
            .count_o        (q_cnt[q]),
            .empty_o        (q_empty[q]),
            .prog_full_o    (ov_queue_prog_full[q]),
            .overflow_clr_i (i_overflow_clr),
            .overflow_o     (ov_queue_overflow[q])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= GW'(NUM_QUEUES - 1);
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        req      = '0;
        req[NUM_QUEUES-1:0] = ~q_empty;
        base     = int'(rr_ptr_q);
        // While busy, the granted head is being popped, so that queue only counts if more remains
        if (state_q == ARB_BUSY) begin
            req[grant_q] = (q_cnt[grant_q] > CNT_W'(1));
            base         = int'(grant_q);
        end
        pick = rr_pick(req, base, NUM_QUEUES);
        case (state_q)
            ARB_IDLE: begin
                if (pick.found) begin
                    grant_d = pick.idx[GW-1:0];
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (beat_valid && tx.p2p_tx_ready && beat_last) begin
                    rr_ptr_d = grant_q;
                    if (pick.found)
                        grant_d = pick.idx[GW-1:0];
                    else
                        state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        cur        = q_dout[grant_q];
        beat_valid = (state_q == ARB_BUSY) && !q_empty[grant_q];
        beat_last  = cur[C_DATA_WIDTH + ENT_END];
        rd_en      = '0;
        rd_en[grant_q] = beat_valid && tx.p2p_tx_ready;
        head = '0;
        head[HEAD_LEN_LO +: ENT_LEN_W] = cur[C_DATA_WIDTH + ENT_LEN_LO +: ENT_LEN_W];
        head[HEAD_SRC_LO +: ENT_DEV_W] = cur[C_DATA_WIDTH + ENT_SRC_LO +: ENT_DEV_W];
        head[HEAD_DST_LO +: ENT_DEV_W] = cur[C_DATA_WIDTH + ENT_DST_LO +: ENT_DEV_W];
    end

    assign tx.p2p_tx_valid = beat_valid;
    assign tx.p2p_tx_last  = beat_last;
    assign tx.p2p_tx_data  = cur[C_DATA_WIDTH-1:0];
    assign tx.p2p_tx_head  = head;

    assign dbg_o.state  = state_q;
    assign dbg_o.rr_ptr = 3'(rr_ptr_q);
    assign dbg_o.grant  = 3'(grant_q);
    assign dbg_o.sop    = cur[C_DATA_WIDTH + ENT_START];
    assign dbg_o.keep   = cur[C_DATA_WIDTH + ENT_KEEP_LO +: ENT_KEEP_W];
    assign dbg_o.rsvd   = cur[C_DATA_WIDTH + ENT_RSVD_LO +: 3];
endmodule
